// File: rtl/inflation_window_feeder.sv
// Raster-to-window feeder: turns a stream of occupancy cells into zero-padded,
// centred KERNEL_SIZE-wide horizontal windows tagged with row/column.
module inflation_window_feeder #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int MAP_WIDTH   = 64,
    parameter int MAP_HEIGHT  = 64,
    localparam int COL_W = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1,
    localparam int ROW_W = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              sync_clr,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_window,
    output logic [COL_W-1:0]                  m_col,
    output logic [ROW_W-1:0]                  m_row,
    output logic                              m_last
);

    localparam int HALF  = KERNEL_SIZE / 2;
    localparam int WIN_W = DATA_WIDTH * KERNEL_SIZE;
    localparam int CNT_W = $clog2(MAP_WIDTH + HALF + 1);

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MAP_WIDTH - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(MAP_WIDTH + HALF - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(MAP_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(MAP_WIDTH - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    localparam state_t START = (HALF > 0) ? FILL : RUN;

    state_t                  state_reg, state_next;
    logic [WIN_W-1:0]        sr_reg, sr_shifted;
    logic [CNT_W-1:0]        in_col_reg;
    logic [ROW_W-1:0]        row_reg;
    logic                    m_valid_reg, m_last_reg;
    logic [WIN_W-1:0]        m_window_reg;
    logic [COL_W-1:0]        m_col_reg;
    logic [ROW_W-1:0]        m_row_reg;

    logic                    loadable, accept, shift_en, load, end_row;
    logic [DATA_WIDTH-1:0]   shift_in;
    logic [COL_W-1:0]        centre_col;

    // Slot k takes slot k+1; the newest cell always enters the rightmost slot.
    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_shift
            assign sr_shifted[gi*DATA_WIDTH +: DATA_WIDTH] = sr_reg[(gi+1)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate
    assign sr_shifted[(KERNEL_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] = shift_in;

    // In-row column counter runs HALF ahead of the window centre.
    assign centre_col = COL_W'(in_col_reg - CNT_W'(HALF));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= START;
        end else if (sync_clr) begin
            state_reg <= START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (accept && in_col_reg == FILL_LAST) state_next = RUN;
            RUN:     if (accept && in_col_reg == RUN_LAST) state_next = (HALF > 0) ? FLUSH : RUN;
            FLUSH:   if (end_row) state_next = FILL;
            default: state_next = START;
        endcase
    end

    always_comb begin
        loadable = !m_valid_reg || m_ready;
        s_ready  = 1'b0;
        shift_in = s_data;
        shift_en = 1'b0;
        load     = 1'b0;
        end_row  = 1'b0;
        case (state_reg)
            FILL:    s_ready = 1'b1;
            RUN:     s_ready = loadable;
            default: s_ready = 1'b0;
        endcase
        accept = s_valid && s_ready;
        case (state_reg)
            FILL: shift_en = accept;
            RUN: begin
                shift_en = accept;
                load     = accept;
                end_row  = accept && (in_col_reg == RUN_LAST) && (HALF == 0);
            end
            FLUSH: begin
                // Right border: push zeros until the last centre column is emitted.
                shift_in = '0;
                shift_en = loadable;
                load     = loadable;
                end_row  = loadable && (in_col_reg == FLUSH_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_reg       <= '0;
            in_col_reg   <= '0;
            row_reg      <= '0;
            m_valid_reg  <= 1'b0;
            m_window_reg <= '0;
            m_col_reg    <= '0;
            m_row_reg    <= '0;
            m_last_reg   <= 1'b0;
        end else if (sync_clr) begin
            sr_reg       <= '0;
            in_col_reg   <= '0;
            row_reg      <= '0;
            m_valid_reg  <= 1'b0;
            m_window_reg <= '0;
            m_col_reg    <= '0;
            m_row_reg    <= '0;
            m_last_reg   <= 1'b0;
        end else begin
            if (end_row) begin
                sr_reg     <= '0;
                in_col_reg <= '0;
                row_reg    <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
            end else if (shift_en) begin
                sr_reg     <= sr_shifted;
                in_col_reg <= in_col_reg + CNT_W'(1);
            end
            if (load) begin
                m_valid_reg  <= 1'b1;
                m_window_reg <= sr_shifted;
                m_col_reg    <= centre_col;
                m_row_reg    <= row_reg;
                m_last_reg   <= (row_reg == ROW_LAST) && (centre_col == COL_LAST);
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_window = m_window_reg;
    assign m_col    = m_col_reg;
    assign m_row    = m_row_reg;
    assign m_last   = m_last_reg;

endmodule

// File: doc/inflation_window_feeder.md
Name: inflation_window_feeder

Overview:
- Upstream feeder for the inflation convolution datapath.
- Accepts a raster stream of occupancy-map cells, one cell per transfer, and emits one zero-padded KERNEL_SIZE-wide horizontal window per cell, centred on that cell.
- The packing matches the concatenated-operand format consumed by the PE/adder-tree stage: slot k sits at bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- Valid/ready on both sides; one window per cycle sustained inside a row.

Parameters:
- KERNEL_SIZE, 3, window length; must be odd and >= 1. HALF = KERNEL_SIZE/2.
- DATA_WIDTH, 8, cell width.
- MAP_WIDTH, 64, cells per row; must be > HALF.
- MAP_HEIGHT, 64, rows per frame.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- sync_clr  in  1  synchronous frame abort; same effect as reset, applied on the clock edge.
- s_valid  in  1  input cell valid.
- s_ready  out  1  input cell accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  input cell value.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream accepts window.
- m_window  out  DATA_WIDTH*KERNEL_SIZE  packed window; slot 0 = leftmost (centre-HALF), slot KERNEL_SIZE-1 = rightmost.
- m_col  out  $clog2(MAP_WIDTH)  centre column of m_window.
- m_row  out  $clog2(MAP_HEIGHT)  row of m_window.
- m_last  out  1  high with the final window of the frame (row MAP_HEIGHT-1, col MAP_WIDTH-1).

Behaviour:
- Reset / sync_clr values:
  - Outputs: m_valid=0, m_window=0, m_col=0, m_row=0, m_last=0.
  - Internal: shift register sr[0..K-1]=0, in_col=0, row=0.
  - State: FILL, or RUN if HALF=0.
- Reset or sync_clr mid-row discards all partial data; the next accepted cell is treated as row 0, col 0. sync_clr has priority over every other event in that cycle.
- Output register: m_window, m_col, m_row and m_last change only when the register is loadable. Loadable means !m_valid || m_ready. Output data is stable while m_valid && !m_ready.
- Shift operation: sr[k] <= sr[k+1] for k < K-1, and sr[K-1] <= new value. The window loaded into the output equals the post-shift sr contents.
- FILL (first HALF cells of a row):
  - s_ready=1; no output load.
  - On accept: shift in s_data, in_col++.
  - When the accepted cell is in_col==HALF-1 -> RUN.
- RUN:
  - s_ready = loadable.
  - On accept: shift in s_data, load the output (m_valid=1, m_col=in_col-HALF, m_row=row), in_col++.
  - When the accepted cell is in_col==MAP_WIDTH-1: -> FLUSH if HALF>0; otherwise end the row.
  - If no accept occurs and m_ready=1, m_valid clears.
- FLUSH:
  - s_ready=0.
  - Each loadable cycle: shift in 0, load the output with the next centre column.
  - After HALF loads, end the row.
- End of row:
  - sr cleared to 0, in_col=0.
  - row++, wrapping MAP_HEIGHT-1 -> 0.
  - Next state is FILL (RUN if HALF=0).
- m_last=1 only on the window whose centre is (MAP_HEIGHT-1, MAP_WIDTH-1). It is 0 on every other window and deasserts once that window is accepted.
- Row timing with m_ready held high: MAP_WIDTH+HALF cycles, producing MAP_WIDTH windows. Bubbles occur only during FILL.
- First window appears 1 cycle after the accept of cell HALF.
- Windows never mix cells from adjacent rows or frames; the left and right borders are zero-padded.
- Cell values pass through unmodified, with no clamping or arithmetic.
- KERNEL_SIZE=1: pure registered pass-through with row/col tagging; FILL and FLUSH are never entered.
- An s_valid drop in any state stalls without state change; FLUSH does not depend on s_valid.

Test Plan:
- K=3, W=4, H=2, m_ready=1, row 0 = 10,20,30,40 -> m_window = 0x140A00, 0x1E140A, 0x281E14, 0x00281E with m_col 0..3 and m_row 0; s_ready=0 for exactly 1 cycle (FLUSH).
- Same stream with m_ready=0 for 3 cycles after the first window -> m_window held at 0x140A00, s_ready=0 while stalled, no cell lost or duplicated; sequence identical to the unstalled case.
- Full frame W=4, H=2 -> m_last=1 only on window row 1 col 3 (0x00281E if row 1 repeats 10..40); the next frame starts at row 0 and its first window has slot 0 = 0 (no carry-over from the previous frame).
- rstn pulsed low after 2 cells of row 1 -> outputs at reset values immediately; the next cells 5,6,7,8 produce 0x060500, 0x070605, 0x080706, 0x000807 tagged row 0.
- sync_clr for 1 cycle mid-FLUSH -> pending window dropped, m_valid=0 next cycle, state FILL at row 0.
- K=1, W=3, H=1, cells 250,253,254 -> windows 0xFA, 0xFD, 0xFE at 1-cycle latency, m_last on col 2, s_ready never deasserts with m_ready=1.
